// File: rtl/softmax_pkg.sv
// Shared definitions for the vector drain/sum block.
// Holds the FSM state encoding and the default element, vector and sum widths.
// Imported by the interface, the top level and the testbench.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int BW_DEF     = 4;
  localparam int LEN_DEF    = 8;
  localparam int SUM_BW_DEF = 8;

endpackage

// File: rtl/fifo_sum_drain_if.sv
// Handshake bundle between the upstream FIFO, the drain block and the result consumer.
// Ports: start/res_ack (requests), fifo_out/fifo_empty/fifo_rd (FIFO read side),
//        sum_out/max_out/res_valid/busy (result side).
interface fifo_sum_drain_if
  import softmax_pkg::*;
#(
  parameter int bw     = BW_DEF,
  parameter int sum_bw = SUM_BW_DEF
);

  logic              start;
  logic [bw-1:0]     fifo_out;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [sum_bw-1:0] sum_out;
  logic [bw-1:0]     max_out;
  logic              res_valid;
  logic              res_ack;
  logic              busy;

  // Environment side: drives requests and FIFO data, observes results.
  modport master (
    output start, fifo_out, fifo_empty, res_ack,
    input  fifo_rd, sum_out, max_out, res_valid, busy
  );

  // Drain block side.
  modport slave (
    input  start, fifo_out, fifo_empty, res_ack,
    output fifo_rd, sum_out, max_out, res_valid, busy
  );

endinterface

// File: rtl/sat_add.sv
// Unsigned saturating adder: y = min(a + b, 2^out_bw - 1), never wraps.
// Ports: a (out_bw, running value), b (in_bw, addend, zero-extended), y (out_bw).
// Purely combinational.
module sat_add #(
  parameter int in_bw  = 4,
  parameter int out_bw = 8
) (
  input  logic [out_bw-1:0] a,
  input  logic [in_bw-1:0]  b,
  output logic [out_bw-1:0] y
);

  // One spare bit above the wider operand catches the carry out.
  localparam int w = ((in_bw > out_bw) ? in_bw : out_bw) + 1;

  localparam logic [out_bw-1:0] sat_max = {out_bw{1'b1}};

  logic [w-1:0] wide;

  always_comb begin
    wide = w'(a) + w'(b);
    if (wide > w'(sat_max)) begin
      y = sat_max;
    end else begin
      y = wide[out_bw-1:0];
    end
  end

endmodule

// File: rtl/fifo_sum_drain.sv
// Drains one vector of len elements from an upstream FIFO on start, producing the
// saturated unsigned sum and the unsigned maximum; the result is held until res_ack.
// Ports: rd_clk, reset (sync, active-high), bus (slave side of fifo_sum_drain_if).
module fifo_sum_drain
  import softmax_pkg::*;
#(
  parameter int bw     = BW_DEF,
  parameter int len    = LEN_DEF,
  parameter int sum_bw = SUM_BW_DEF
) (
  input  logic             rd_clk,
  input  logic             reset,
  fifo_sum_drain_if.slave  bus
);

  localparam int cw = $clog2(len + 1);

  state_t            state;
  logic [sum_bw-1:0] acc;
  logic [sum_bw-1:0] acc_next;
  logic [bw-1:0]     max_r;
  logic [cw-1:0]     count;
  logic              res_valid_r;
  logic              busy_r;
  logic              rd;

  // FIFO data is combinational from its read pointer, so the element is
  // consumed in the same cycle the strobe is raised. Reset gates the strobe
  // so a half-drained vector leaves its remaining entries in the FIFO.
  assign rd = (state == DRAIN) && !bus.fifo_empty && !reset;

  sat_add #(
    .in_bw  (bw),
    .out_bw (sum_bw)
  ) u_sat_add (
    .a (acc),
    .b (bus.fifo_out),
    .y (acc_next)
  );

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      max_r       <= '0;
      count       <= '0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= DRAIN;
            acc    <= '0;
            max_r  <= '0;
            count  <= '0;
            busy_r <= 1'b1;
          end
        end
        DRAIN: begin
          // An empty FIFO simply stalls here; there is no timeout.
          if (rd) begin
            acc   <= acc_next;
            count <= count + cw'(1);
            if (bus.fifo_out > max_r) begin
              max_r <= bus.fifo_out;
            end
            if (count == cw'(len - 1)) begin
              state       <= HOLD;
              res_valid_r <= 1'b1;
            end
          end
        end
        HOLD: begin
          // start is dropped here even if it coincides with res_ack.
          if (bus.res_ack) begin
            state       <= IDLE;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_rd   = rd;
  assign bus.sum_out   = acc;
  assign bus.max_out   = max_r;
  assign bus.res_valid = res_valid_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_fifo_sum_drain.sv
// Directed bench for fifo_sum_drain: two instances share stimulus, one with the
// default sum width and one with sum_bw=6 to exercise saturation.
// A queue models the upstream FIFO, popped on every edge where fifo_rd was high.
module tb_fifo_sum_drain;
  import softmax_pkg::*;

  logic       rd_clk;
  logic       reset;
  logic       start;
  logic       res_ack;
  logic [3:0] fifo_out;
  logic       fifo_empty;

  logic [3:0] q[$];
  logic       rd_seen;
  int         n_err;
  int         n_chk;

  fifo_sum_drain_if #(.bw(4), .sum_bw(8)) ia ();
  fifo_sum_drain_if #(.bw(4), .sum_bw(6)) ib ();

  assign ia.start      = start;
  assign ia.res_ack    = res_ack;
  assign ia.fifo_out   = fifo_out;
  assign ia.fifo_empty = fifo_empty;
  assign ib.start      = start;
  assign ib.res_ack    = res_ack;
  assign ib.fifo_out   = fifo_out;
  assign ib.fifo_empty = fifo_empty;

  fifo_sum_drain #(.bw(4), .len(8), .sum_bw(8)) ua (
    .rd_clk (rd_clk),
    .reset  (reset),
    .bus    (ia)
  );

  fifo_sum_drain #(.bw(4), .len(8), .sum_bw(6)) ub (
    .rd_clk (rd_clk),
    .reset  (reset),
    .bus    (ib)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic upd();
    fifo_empty = (q.size() == 0);
    fifo_out   = (q.size() != 0) ? q[0] : 4'd0;
  endtask

  task automatic push(input int v);
    q.push_back(4'(v));
    upd();
  endtask

  // One clock: note the strobe mid-cycle, pop after the edge, settle.
  task automatic tick();
    @(negedge rd_clk);
    rd_seen = ia.fifo_rd;
    @(posedge rd_clk);
    #1;
    if (rd_seen) void'(q.pop_front());
    upd();
    #1;
  endtask

  initial begin
    n_err   = 0;
    n_chk   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    res_ack = 1'b0;
    upd();
    tick();
    tick();

    // Reset state
    chk("rst_sum", ia.sum_out, 0);
    chk("rst_max", ia.max_out, 0);
    chk("rst_valid", ia.res_valid, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_rd", ia.fifo_rd, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", ia.busy, 0);

    // 1..8: eight consecutive reads, sum 36, max 8
    for (int i = 1; i <= 8; i++) push(i);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_rd%0d", i), ia.fifo_rd, 1);
      tick();
    end
    chk("t1_valid", ia.res_valid, 1);
    chk("t1_sum", ia.sum_out, 36);
    chk("t1_max", ia.max_out, 8);
    chk("t1_rd_after", ia.fifo_rd, 0);
    chk("t1_qsize", q.size(), 0);
    chk("t1_b_sum", ib.sum_out, 36);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("t1_ack_valid", ia.res_valid, 0);
    chk("t1_ack_busy", ia.busy, 0);
    chk("t1_keep_sum", ia.sum_out, 36);
    chk("t1_keep_max", ia.max_out, 8);

    // Eight 15s: 120 in 8 bits, saturates to 63 in 6 bits
    for (int i = 0; i < 8; i++) push(15);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t2_valid", ia.res_valid, 1);
    chk("t2_a_sum", ia.sum_out, 120);
    chk("t2_b_sum", ib.sum_out, 63);
    chk("t2_b_max", ib.max_out, 15);
    chk("t2_b_valid", ib.res_valid, 1);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;

    // FIFO runs dry after 3 elements, refilled 5 cycles later
    push(2); push(9); push(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_gap_rd%0d", i), ia.fifo_rd, 0);
      chk($sformatf("t3_gap_sum%0d", i), ia.sum_out, 15);
      tick();
    end
    chk("t3_gap_busy", ia.busy, 1);
    chk("t3_gap_valid", ia.res_valid, 0);
    chk("t3_gap_max", ia.max_out, 9);
    push(1); push(3); push(12); push(0); push(5);
    #1;
    chk("t3_refill_rd", ia.fifo_rd, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_valid", ia.res_valid, 1);
    chk("t3_sum", ia.sum_out, 36);
    chk("t3_max", ia.max_out, 12);
    chk("t3_b_sum", ib.sum_out, 36);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;

    // Reset after 4 reads abandons the vector, the rest stays queued
    for (int i = 0; i < 4; i++) push(1);
    for (int i = 2; i <= 9; i++) push(i);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    chk("t4_rd_in_rst", ia.fifo_rd, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("t4_busy", ia.busy, 0);
    chk("t4_rd", ia.fifo_rd, 0);
    chk("t4_sum", ia.sum_out, 0);
    chk("t4_qsize", q.size(), 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t4_valid", ia.res_valid, 1);
    chk("t4_sum2", ia.sum_out, 44);
    chk("t4_max2", ia.max_out, 9);
    chk("t4_b_sum2", ib.sum_out, 44);

    // HOLD with no ack for 10 cycles; start is ignored, FIFO has data
    for (int i = 0; i < 8; i++) push(3);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      chk($sformatf("t5_valid%0d", i), ia.res_valid, 1);
      chk($sformatf("t5_rd%0d", i), ia.fifo_rd, 0);
      chk($sformatf("t5_sum%0d", i), ia.sum_out, 44);
      tick();
    end
    chk("t5_max", ia.max_out, 9);
    res_ack = 1'b1;
    start   = 1'b1;
    tick();
    res_ack = 1'b0;
    start   = 1'b0;
    chk("t5_ack_busy", ia.busy, 0);
    chk("t5_ack_valid", ia.res_valid, 0);
    tick();
    chk("t5_no_drain_busy", ia.busy, 0);
    chk("t5_no_drain_rd", ia.fifo_rd, 0);
    chk("t5_qsize", q.size(), 8);

    // Back-to-back vectors; res_ack outside HOLD is ignored
    push(10);
    for (int i = 0; i < 6; i++) push(0);
    push(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_sum1", ia.sum_out, 24);
    chk("t6_max1", ia.max_out, 3);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("t6_idle", ia.busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_cleared_sum", ia.sum_out, 0);
    chk("t6_cleared_max", ia.max_out, 0);
    res_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) res_ack = 1'b0;
      tick();
    end
    chk("t6_valid", ia.res_valid, 1);
    chk("t6_sum2", ia.sum_out, 11);
    chk("t6_max2", ia.max_out, 10);
    chk("t6_b_sum2", ib.sum_out, 11);
    chk("t6_qsize", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
